muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit_sign_fix.sv | 53 +++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_unit_pkg;

  // Operation codes presented on i_operation (6 and 7 are no-ops).
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  // MULT/MULTU/DIV/DIVU run through the iterative datapath.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Even arithmetic opcodes (MULT, DIV) are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes at issue, result
// negation and HI/LO selection in the fix-up cycle.
module muldiv_sign_fix #(
  parameter int NB = 32
) (
  input  logic [NB-1:0]   i_op_a,
  input  logic [NB-1:0]   i_op_b,
  input  logic            i_op_signed,
  input  logic [2*NB-1:0] i_acc,
  input  logic            i_fix_div,
  input  logic            i_fix_signed,
  input  logic            i_sign_a,
  input  logic            i_sign_b,
  input  logic            i_div_zero,
  input  logic [NB-1:0]   i_dividend,
  output logic [NB-1:0]   o_abs_a,
  output logic [NB-1:0]   o_abs_b,
  output logic [NB-1:0]   o_hi,
  output logic [NB-1:0]   o_lo
);

  logic [2*NB-1:0] prod_fix;
  logic [NB-1:0]   quo;
  logic [NB-1:0]   rem;
  logic            neg_res;

  // Magnitudes of the issuing operands; 0x80000000 maps onto itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    o_abs_a = (i_op_signed && i_op_a[NB-1]) ? -i_op_a : i_op_a;
    o_abs_b = (i_op_signed && i_op_b[NB-1]) ? -i_op_b : i_op_b;
  end

  // Sign correction and HI/LO selection of the finished accumulator.
  always_comb begin
    neg_res  = i_fix_signed && (i_sign_a ^ i_sign_b);
    prod_fix = neg_res ? -i_acc : i_acc;
    quo      = i_acc[NB-1:0];
    rem      = i_acc[2*NB-1:NB];
    o_hi     = prod_fix[2*NB-1:NB];
    o_lo     = prod_fix[NB-1:0];
    if (i_fix_div) begin
      if (i_div_zero) begin
        o_lo = '1;
        o_hi = i_dividend;
      end else begin
        o_lo = neg_res ? -quo : quo;
        o_hi = (i_fix_signed && i_sign_a) ? -rem : rem;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int NB    = 32,
  parameter int NB_OP = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [NB_OP-1:0] i_operation,
  input  logic [NB-1:0]    i_data_a,
  input  logic [NB-1:0]    i_data_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [NB-1:0]    o_hi,
  output logic [NB-1:0]    o_lo
);

  localparam int unsigned NB_CNT = $clog2(NB);

  muldiv_state_e     state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [2*NB-1:0]   acc_q, acc_d;
  logic [NB-1:0]     opnd_q, opnd_d;
  logic [NB-1:0]     dividend_q, dividend_d;
  logic              is_div_q, is_div_d;
  logic              is_signed_q, is_signed_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [NB-1:0]     hi_q, hi_d;
  logic [NB-1:0]     lo_q, lo_d;
  logic              done_q, done_d;

  logic [2:0]        op;
  logic              op_signed;
  logic [NB-1:0]     abs_a, abs_b;
  logic [NB-1:0]     fix_hi, fix_lo;

  logic [NB:0]       mul_sum;
  logic [2*NB-1:0]   mul_next;
  logic [NB:0]       div_shift;
  logic [NB:0]       div_diff;
  logic [2*NB-1:0]   div_next;

  assign op        = i_operation[2:0];
  assign op_signed = op_is_signed(op);

  muldiv_sign_fix #(
    .NB (NB)
  ) u_sign_fix (
    .i_op_a       (i_data_a),
    .i_op_b       (i_data_b),
    .i_op_signed  (op_signed),
    .i_acc        (acc_q),
    .i_fix_div    (is_div_q),
    .i_fix_signed (is_signed_q),
    .i_sign_a     (sign_a_q),
    .i_sign_b     (sign_b_q),
    .i_div_zero   (opnd_q == '0),
    .i_dividend   (dividend_q),
    .o_abs_a      (abs_a),
    .o_abs_b      (abs_b),
    .o_hi         (fix_hi),
    .o_lo         (fix_lo)
  );

  // One radix-2 step: the accumulator holds {partial, multiplier} for
  // multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*NB-1:NB]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[NB-1:1]};
    div_shift = {acc_q[2*NB-1:NB], acc_q[NB-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[NB] ? {div_shift[NB-1:0], acc_q[NB-2:0], 1'b0}
                             : {div_diff[NB-1:0],  acc_q[NB-2:0], 1'b1};
  end

  // Sequencer and datapath next-state; flush is evaluated before issue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    dividend_d  = dividend_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_flush && i_valid) begin
          if (op_is_arith(op)) begin
            state_d     = ST_CALC;
            cnt_d       = NB_CNT'(NB - 1);
            is_div_d    = op[1];
            is_signed_d = op_signed;
            sign_a_d    = op_signed & i_data_a[NB-1];
            sign_b_d    = op_signed & i_data_b[NB-1];
            dividend_d  = i_data_a;
            opnd_d      = abs_b;
            acc_d       = {{NB{1'b0}}, abs_a};
          end else if (op == OP_MTHI) begin
            hi_d = i_data_a;
          end else if (op == OP_MTLO) begin
            lo_d = i_data_a;
          end
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      dividend_q  <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      dividend_q  <= dividend_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected
// HI/LO, a monitor pops and compares on every o_done pulse.
module tb_muldiv_unit;

  localparam logic [2:0] C_MULT  = 3'd0;
  localparam logic [2:0] C_MULTU = 3'd1;
  localparam logic [2:0] C_DIV   = 3'd2;
  localparam logic [2:0] C_DIVU  = 3'd3;
  localparam logic [2:0] C_MTHI  = 3'd4;
  localparam logic [2:0] C_MTLO  = 3'd5;
  localparam logic [2:0] C_NOP6  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  muldiv_unit #(
    .NB    (32),
    .NB_OP (3)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_valid     (valid),
    .i_operation (op),
    .i_data_a    (a),
    .i_data_b    (b),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_done      (done),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
  endtask

  // Issue one arithmetic op and measure busy length and done alignment.
  task automatic run_op(input string name, input logic [2:0] opc,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    push_exp(eh, el);
    @(negedge clk);
    valid = 1'b1; op = opc; a = da; b = db;
    @(negedge clk);
    valid = 1'b0; a = '0; b = '0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, 32'd33);
    check({name, "_done_after_busy"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
        end else begin
          e = sb.pop_front();
          check("done_hi", hi, e.hi);
          check("done_lo", lo, e.lo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    run_op("mult_neg",   C_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max",  C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_7_2",   C_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003);
    run_op("div_m7_2",   C_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",    C_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_zero",   C_DIV,   32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF);
    run_op("div_zero_n", C_DIV,   32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF);

    // MTHI takes effect right after the issue edge without going busy.
    @(negedge clk);
    valid = 1'b1; op = C_MTHI; a = 32'hCAFEBABE;
    @(negedge clk);
    valid = 1'b0; a = '0;
    check("mthi_hi", hi, 32'hCAFEBABE);
    check("mthi_lo_kept", lo, 32'hFFFFFFFF);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);

    // Flush in IDLE suppresses a same-cycle MTLO.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = C_MTLO; a = 32'h00000001;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; a = '0;
    check("flush_idle_lo", lo, 32'hFFFFFFFF);

    // No-op opcode leaves everything alone.
    @(negedge clk);
    valid = 1'b1; op = C_NOP6; a = 32'h11111111; b = 32'h22222222;
    @(negedge clk);
    valid = 1'b0; a = '0; b = '0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'hCAFEBABE);
    check("nop_lo", lo, 32'hFFFFFFFF);

    // MTLO presented while a MULT is busy must be ignored.
    push_exp(32'h0, 32'h00000023);
    @(negedge clk);
    valid = 1'b1; op = C_MULT; a = 32'd5; b = 32'd7;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    valid = 1'b1; op = C_MTLO; a = 32'd5;
    @(negedge clk);
    valid = 1'b0; a = '0; b = '0;
    @(negedge clk);
    check("busy_mtlo_lo", lo, 32'hFFFFFFFF);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_mtlo_done", {31'd0, done}, 32'd1);
    check("busy_mtlo_final_lo", lo, 32'h00000023);
    @(negedge clk);

    // Flush at cycle 10 of a MULT: idle next cycle, HI/LO untouched, no done.
    @(negedge clk);
    valid = 1'b1; op = C_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    valid = 1'b0; a = '0; b = '0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_hi", hi, 32'h0);
    check("flush_lo", lo, 32'h00000023);
    repeat (40) @(negedge clk);
    check("flush_still_idle", {31'd0, busy}, 32'd0);
    check("flush_lo_after", lo, 32'h00000023);

    // Reset at cycle 20 of a MULT clears everything.
    @(negedge clk);
    valid = 1'b1; op = C_MULTU; a = 32'hFFFFFFFF; b = 32'd2;
    @(negedge clk);
    valid = 1'b0; a = '0; b = '0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
